alu_cc_unit: RTL and testbench

Parametrised, pipelined successor to the combinational Y86 ALU: performs add/sub/and/xor on two WIDTH-bit signed operands, carries results through LATENCY register stages under a valid/ready handshake, and owns the architectural condition-code register (ZF, SF, OF). It sits in the execute stage, feeding valE to memory/write-back and the `cnd` flag to cmovXX/jXX handling.

---
 rtl/alu_cc_unit.sv | 106 ++++++++++
 tb/tb_alu_cc_unit.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cc_unit.sv
// Pipelined Y86 execute ALU: add/sub/and/xor with signed overflow, LATENCY register
// stages under valid/ready, and the architectural {ZF,SF,OF} condition-code register.
module alu_cc_unit #(
  parameter int WIDTH   = 64,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       alu_fun,
  input  logic             set_cc,
  input  logic [2:0]       cond_fun,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             of,
  output logic             cnd,
  output logic [2:0]       cc
);

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             ovf;
    logic             set_cc;
    logic [2:0]       cond_fun;
  } stage_t;

  stage_t             stg_d;
  stage_t             stg_q [1:LATENCY];
  logic [LATENCY:1]   vld_pipe;
  logic [WIDTH-1:0]   sum, dif;
  logic               stall, retire;
  logic               zf, sf, ovf_cc, lt;

  // Stage-1 compute; later stages only carry these values.
  always_comb begin
    sum            = a + b;
    dif            = a - b;
    stg_d          = '0;
    stg_d.set_cc   = set_cc;
    stg_d.cond_fun = cond_fun;
    case (alu_fun)
      2'b00: begin
        stg_d.res = sum;
        stg_d.ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      2'b01: begin
        stg_d.res = dif;
        stg_d.ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      2'b10:   stg_d.res = a & b;
      default: stg_d.res = a ^ b;
    endcase
  end

  assign out_valid = vld_pipe[LATENCY];
  assign result    = stg_q[LATENCY].res;
  assign of        = stg_q[LATENCY].ovf;
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;
  assign retire    = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      cc       <= 3'b100;
      for (int i = 1; i <= LATENCY; i++) stg_q[i] <= '0;
    end else begin
      if (!stall) begin
        vld_pipe[1] <= in_valid;
        stg_q[1]    <= stg_d;
        for (int i = 2; i <= LATENCY; i++) begin
          vld_pipe[i] <= vld_pipe[i-1];
          stg_q[i]    <= stg_q[i-1];
        end
      end
      // Flush beats both the shift and a same-cycle retire's CC write.
      if (flush) vld_pipe <= '0;
      if (retire && !flush && stg_q[LATENCY].set_cc)
        cc <= {result == '0, result[WIDTH-1], of};
    end
  end

  // Condition sees CC as it stands before this op's own update.
  always_comb begin
    zf     = cc[2];
    sf     = cc[1];
    ovf_cc = cc[0];
    lt     = sf ^ ovf_cc;
    case (stg_q[LATENCY].cond_fun)
      3'd0:    cnd = 1'b1;
      3'd1:    cnd = lt | zf;
      3'd2:    cnd = lt;
      3'd3:    cnd = zf;
      3'd4:    cnd = !zf;
      3'd5:    cnd = !lt;
      3'd6:    cnd = !lt && !zf;
      default: cnd = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_alu_cc_unit.sv
// Bench for alu_cc_unit: scoreboarded 64-bit/3-stage instance plus directed
// literal checks on a 64-bit/1-stage and an 8-bit/2-stage instance.
module tb_alu_cc_unit;
  localparam int W = 64;
  localparam int L = 3;
  localparam logic [63:0] SMAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SMIN = 64'h8000_0000_0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errs = 0, checks = 0;

  // main instance
  logic rst_n, fl, iv, ordy, sc;
  logic [W-1:0] av, bv;
  logic [1:0] fn;
  logic [2:0] cf;
  logic rdy, ov, ofl, cn;
  logic [W-1:0] res;
  logic [2:0] ccv;

  alu_cc_unit #(.WIDTH(W), .LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .flush(fl), .in_valid(iv), .in_ready(rdy),
    .a(av), .b(bv), .alu_fun(fn), .set_cc(sc), .cond_fun(cf),
    .out_valid(ov), .out_ready(ordy), .result(res), .of(ofl), .cnd(cn), .cc(ccv));

  // latency-1 and 8-bit instances
  logic zero = 1'b0, one = 1'b1;
  logic iv1, sc1;
  logic [63:0] a1, b1;
  logic [1:0] f1;
  logic [2:0] cf1;
  logic rdy1, ov1, of1, cn1;
  logic [63:0] r1;
  logic [2:0] cc1;

  alu_cc_unit #(.WIDTH(64), .LATENCY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(zero), .in_valid(iv1), .in_ready(rdy1),
    .a(a1), .b(b1), .alu_fun(f1), .set_cc(sc1), .cond_fun(cf1),
    .out_valid(ov1), .out_ready(one), .result(r1), .of(of1), .cnd(cn1), .cc(cc1));

  logic iv8;
  logic [7:0] a8, b8;
  logic [1:0] f8;
  logic [2:0] cf8 = 3'd0;
  logic rdy8, ov8, of8, cn8;
  logic [7:0] r8;
  logic [2:0] cc8;

  alu_cc_unit #(.WIDTH(8), .LATENCY(2)) u8 (
    .clk(clk), .rst_n(rst_n), .flush(zero), .in_valid(iv8), .in_ready(rdy8),
    .a(a8), .b(b8), .alu_fun(f8), .set_cc(zero), .cond_fun(cf8),
    .out_valid(ov8), .out_ready(one), .result(r8), .of(of8), .cnd(cn8), .cc(cc8));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic       v;
    logic [W-1:0] r;
    logic       o;
    logic       s;
    logic [2:0] c;
  } ent_t;

  ent_t mq [L];        // mq[0] = youngest slot, mq[L-1] = output slot
  logic [2:0] mcc;
  bit mdl_on = 0;
  bit m_stall, m_head;

  function automatic ent_t mk(logic v, logic [1:0] f, logic [W-1:0] x, logic [W-1:0] y,
                              logic s, logic [2:0] c);
    logic signed [W:0] t;
    ent_t e;
    case (f)
      2'd0:    t = $signed({x[W-1], x}) + $signed({y[W-1], y});
      2'd1:    t = $signed({x[W-1], x}) - $signed({y[W-1], y});
      2'd2:    t = {1'b0, x & y};
      default: t = {1'b0, x ^ y};
    endcase
    e.v = v; e.r = t[W-1:0]; e.s = s; e.c = c;
    // exact signed result not representable in W bits
    e.o = (f < 2) && (t > $signed({1'b0, SMAX}) || t < $signed({1'b1, SMIN}));
    return e;
  endfunction

  function automatic logic mcond(logic [2:0] c, logic [2:0] f);
    logic z, less;
    z = c[2];
    less = (c[1] != c[0]);
    case (f)
      3'd0: return 1'b1;
      3'd1: return less || z;
      3'd2: return less;
      3'd3: return z;
      3'd4: return !z;
      3'd5: return !less;
      3'd6: return !less && !z;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < L; i++) mq[i] = '0;
      mcc = 3'b100;
      mdl_on = 1;
    end else if (mdl_on) begin
      m_head = mq[L-1].v;
      m_stall = m_head && !ordy;
      if (m_head && ordy && !fl && mq[L-1].s)
        mcc = {mq[L-1].r == 0, mq[L-1].r[W-1], mq[L-1].o};
      if (!m_stall) begin
        for (int i = L-1; i > 0; i--) mq[i] = mq[i-1];
        mq[0] = mk(iv, fn, av, bv, sc, cf);
      end
      if (fl) for (int i = 0; i < L; i++) mq[i].v = 1'b0;
    end
  end

  logic [65:0] log_q [$];

  always @(negedge clk) begin
    if (mdl_on) begin
      chk("in_ready", rdy, !(mq[L-1].v && !ordy));
      chk("out_valid", ov, mq[L-1].v);
      chk("cc", ccv, mcc);
      if (mq[L-1].v) begin
        chk("result", res, mq[L-1].r);
        chk("of", ofl, mq[L-1].o);
        chk("cnd", cn, mcond(mcc, mq[L-1].c));
      end
      if (ov && ordy && !fl) log_q.push_back({res, ofl, cn});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] f, input logic [63:0] x, input logic [63:0] y,
                      input logic s, input logic [2:0] c);
    logic acc;
    int tries;
    fn = f; av = x; bv = y; sc = s; cf = c; iv = 1'b1;
    tries = 0;
    do begin
      #1;
      acc = rdy;
      step();
      tries++;
    end while (!acc && tries < 50);
    if (!acc) begin
      checks++; errs++;
      $display("FAIL send: op not accepted within 50 cycles");
    end
  endtask

  task automatic chk_log(input int idx, input string nm, input logic [63:0] er,
                         input logic eo, input logic ec);
    if (idx >= log_q.size()) begin
      checks++; errs++;
      $display("FAIL %s: retirement #%0d missing, have %0d", nm, idx, log_q.size());
    end else begin
      chk({nm, " res"}, log_q[idx][65:2], er);
      chk({nm, " of"}, {63'd0, log_q[idx][1]}, {63'd0, eo});
      chk({nm, " cnd"}, {63'd0, log_q[idx][0]}, {63'd0, ec});
    end
  endtask

  task automatic u1_op(input logic [1:0] f, input logic [63:0] x, input logic [63:0] y,
                       input logic s, input logic [2:0] c, input logic [63:0] er,
                       input logic eo, input logic ec, input string nm);
    f1 = f; a1 = x; b1 = y; sc1 = s; cf1 = c; iv1 = 1'b1;
    step();
    chk({nm, " valid"}, ov1, 1);
    chk({nm, " res"}, r1, er);
    chk({nm, " of"}, of1, eo);
    chk({nm, " cnd"}, cn1, ec);
  endtask

  task automatic u8_op(input logic [1:0] f, input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] er, input logic eo, input string nm);
    f8 = f; a8 = x; b8 = y; iv8 = 1'b1;
    step();
    iv8 = 1'b0;
    chk({nm, " early"}, ov8, 0);
    step();
    chk({nm, " valid"}, ov8, 1);
    chk({nm, " res"}, r8, er);
    chk({nm, " of"}, of8, eo);
    step();
    chk({nm, " single"}, ov8, 0);
  endtask

  function automatic logic [63:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return SMAX;
      2: return SMIN;
      3: return '1;
      4: return 64'd1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  int base;

  initial begin
    rst_n = 1'b0; fl = 1'b0; ordy = 1'b1;
    iv = 1'b1; fn = 2'd0; av = 64'd5; bv = 64'd6; sc = 1'b1; cf = 3'd2;
    iv1 = 1'b1; f1 = 2'd0; a1 = 64'd1; b1 = 64'd1; sc1 = 1'b1; cf1 = 3'd0;
    iv8 = 1'b1; f8 = 2'd0; a8 = 8'd1; b8 = 8'd1;

    // reset with in_valid held high
    step(); step();
    chk("rst out_valid", ov, 0);
    chk("rst cc", ccv, 3'b100);
    chk("rst in_ready", rdy, 1);
    chk("rst result", res, 0);
    chk("rst cnd", cn, 1);
    chk("rst u1 out_valid", ov1, 0);
    chk("rst u8 cc", cc8, 3'b100);
    rst_n = 1'b1; iv = 1'b0; iv1 = 1'b0; iv8 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("post-rst idle", ov, 0);
    end

    // directed ops, back to back on the 3-stage instance
    base = log_q.size();
    send(2'd0, 64'd3, 64'd1, 1'b0, 3'd0);
    send(2'd1, 64'd34, 64'd12, 1'b0, 3'd0);
    send(2'd2, 64'd12, 64'd34, 1'b0, 3'd0);
    send(2'd3, 64'd1112, 64'd345, 1'b0, 3'd0);
    send(2'd0, SMAX, 64'd1, 1'b1, 3'd0);
    send(2'd1, 64'd1, 64'd1, 1'b1, 3'd3);
    send(2'd0, 64'd0, 64'd0, 1'b0, 3'd3);
    send(2'd0, 64'd0, 64'd0, 1'b0, 3'd6);
    iv = 1'b0;
    for (int k = 0; k < 6; k++) step();
    chk_log(base + 0, "add", 64'd4, 0, 1);
    chk_log(base + 1, "sub", 64'd22, 0, 1);
    chk_log(base + 2, "and", 64'd0, 0, 1);
    chk_log(base + 3, "xor", 64'd1281, 0, 1);
    chk_log(base + 4, "ovf add", SMIN, 1, 1);
    chk_log(base + 5, "sub after ovf", 64'd0, 0, 0);
    chk_log(base + 6, "cnd e", 64'd0, 0, 1);
    chk_log(base + 7, "cnd g", 64'd0, 0, 0);
    chk("cc after directed", ccv, 3'b100);

    // backpressure: out_ready 1,0,0,1,0,0,...
    base = log_q.size();
    fork
      begin
        for (int k = 0; k < 6; k++) send(2'd0, 64'(100 + k), 64'd7, 1'b0, 3'd0);
        iv = 1'b0;
      end
      begin
        for (int k = 0; k < 30; k++) begin
          ordy = (k % 3 == 0);
          step();
        end
      end
    join
    ordy = 1'b1;
    for (int k = 0; k < 5; k++) step();
    chk("bp count", log_q.size(), base + 6);
    for (int k = 0; k < 6; k++) chk_log(base + k, "bp order", 64'(107 + k), 0, 1);

    // flush with ops in flight, including one offered in the flush cycle
    base = log_q.size();
    send(2'd0, 64'd5, 64'd6, 1'b1, 3'd0);
    send(2'd0, 64'd7, 64'd8, 1'b1, 3'd0);
    fn = 2'd1; av = 64'd9; bv = 64'd9; sc = 1'b1; iv = 1'b1; fl = 1'b1;
    step();
    fl = 1'b0; iv = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("flush no out", ov, 0);
    end
    chk("flush cc", ccv, 3'b100);
    chk("flush log", log_q.size(), base);
    send(2'd0, 64'd2, 64'd2, 1'b1, 3'd0);
    iv = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk_log(base, "post-flush op", 64'd4, 0, 1);
    chk("post-flush cc", ccv, 3'b000);

    // random traffic
    for (int k = 0; k < 800; k++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 9) < 7);
      fl   = ($urandom_range(0, 24) == 0);
      fn   = 2'($urandom_range(0, 3));
      av   = rnd_opnd();
      bv   = rnd_opnd();
      sc   = 1'($urandom_range(0, 1));
      cf   = 3'($urandom_range(0, 7));
      step();
    end
    iv = 1'b0; fl = 1'b0; ordy = 1'b1;
    for (int k = 0; k < 5; k++) step();

    // latency-1 instance
    chk("u1 idle", ov1, 0);
    u1_op(2'd0, 64'd3, 64'd1, 1'b0, 3'd0, 64'd4, 0, 1, "u1 add");
    u1_op(2'd1, 64'd34, 64'd12, 1'b0, 3'd0, 64'd22, 0, 1, "u1 sub");
    u1_op(2'd2, 64'd12, 64'd34, 1'b0, 3'd0, 64'd0, 0, 1, "u1 and");
    u1_op(2'd3, 64'd1112, 64'd345, 1'b0, 3'd0, 64'd1281, 0, 1, "u1 xor");
    u1_op(2'd0, SMAX, 64'd1, 1'b1, 3'd0, SMIN, 1, 1, "u1 ovf");
    u1_op(2'd1, 64'd1, 64'd1, 1'b1, 3'd3, 64'd0, 0, 0, "u1 sub0");
    chk("u1 cc ovf", cc1, 3'b011);
    u1_op(2'd0, 64'd0, 64'd0, 1'b0, 3'd3, 64'd0, 0, 1, "u1 e");
    chk("u1 cc zero", cc1, 3'b100);
    u1_op(2'd0, 64'd0, 64'd0, 1'b0, 3'd6, 64'd0, 0, 0, "u1 g");
    iv1 = 1'b0;
    step();
    chk("u1 drained", ov1, 0);

    // 8-bit instance
    u8_op(2'd0, 8'h7F, 8'h01, 8'h80, 1, "u8 add");
    u8_op(2'd1, 8'h80, 8'h01, 8'h7F, 1, "u8 sub");
    u8_op(2'd3, 8'hF0, 8'hFF, 8'h0F, 0, "u8 xor");
    chk("u8 cnd", cn8, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
